regfile_scoreboard: RTL and testbench

Parametrised register file for the decode stage with an N-read/M-write port array, same-cycle write-through bypass and a per-register pending-write scoreboard. Decode reads operands combinationally while writeback commits results in the same cycle. Decode claims destinations of long-latency producers, such as loads, so that hazard logic can stall on `rready` instead of relying on forwarding alone. It succeeds the fixed 2-read/1-write register file used by the current decode stage.

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard for decode hazard checks.
// Reads and rready are combinational (0 cycles), state updates on the next edge; no handshake, never stalls.
module regfile_scoreboard #(
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int ADDR        = 5,
    parameter int WIDTH       = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [WRITE_PORTS-1:0]                we,
    input  logic [WRITE_PORTS-1:0][ADDR-1:0]      waddr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]     wdata,
    input  logic [READ_PORTS-1:0][ADDR-1:0]       raddr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]      rdata,
    output logic [READ_PORTS-1:0]                 rready,
    input  logic                                  claim_valid,
    input  logic [ADDR-1:0]                       claim_addr,
    input  logic                                  flush,
    output logic [$clog2(2**ADDR+1)-1:0]          pending_count
);

    localparam int DEPTH = 2**ADDR;
    localparam int CW    = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wr_hit;
    logic [WIDTH-1:0] wr_dat [DEPTH];
    logic [DEPTH-1:0] claim_hit;
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [DEPTH-1:0] cleared;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    clr_cnt;
    logic             set_new;

    // Per-entry write decode; ascending port order lets the highest port win a collision.
    // Writes are masked while reset is held so the bypass cannot leak data during reset.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_dat[i] = '0;
        end
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (reset && we[w] && (waddr[w] != '0)) begin
                wr_hit[waddr[w]] = 1'b1;
                wr_dat[waddr[w]] = wdata[w];
            end
        end
    end

    always_comb begin
        claim_hit = '0;
        if (claim_valid && (claim_addr != '0)) begin
            claim_hit[claim_addr] = 1'b1;
        end
    end

    // Register 0 is never written or claimed, so it reads 0 and is always ready.
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            if (wr_hit[raddr[r]]) begin
                rdata[r]  = wr_dat[raddr[r]];
                rready[r] = 1'b1;
            end else begin
                rdata[r]  = mem_q[raddr[r]];
                rready[r] = !pend_q[raddr[r]];
            end
        end
    end

    // A claim on a register being written in the same cycle wins: it is the newer producer.
    always_comb begin
        cleared = pend_q & wr_hit & ~claim_hit;
        set_new = |(claim_hit & ~pend_q);
        clr_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_cnt = clr_cnt + CW'(cleared[i]);
        end
        if (flush) begin
            pend_d = '0;
            cnt_d  = '0;
        end else begin
            pend_d = (pend_q & ~wr_hit) | claim_hit;
            cnt_d  = cnt_q + CW'(set_new) - clr_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    mem_q[i] <= wr_dat[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_count = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (2 read / 2 write ports): directed table, random vs reference model, reset cases.
module tb_regfile_scoreboard;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        we = '0;
    logic [1:0][4:0]   waddr = '0;
    logic [1:0][31:0]  wdata = '0;
    logic [1:0][4:0]   raddr = '0;
    logic [1:0][31:0]  rdata;
    logic [1:0]        rready;
    logic              claim_valid = 1'b0;
    logic [4:0]        claim_addr = '0;
    logic              flush = 1'b0;
    logic [5:0]        pending_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    regfile_scoreboard #(
        .READ_PORTS (2),
        .WRITE_PORTS(2),
        .ADDR       (5),
        .WIDTH      (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        (raddr),
        .rdata        (rdata),
        .rready       (rready),
        .claim_valid  (claim_valid),
        .claim_addr   (claim_addr),
        .flush        (flush),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents plus a set of pending registers.
    logic [31:0] m_mem  [32];
    bit          m_pend [32];

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            m_mem[a]  = '0;
            m_pend[a] = 1'b0;
        end
    endtask

    function automatic void model_read(input int a, output logic [31:0] d, output logic rdy);
        d   = m_mem[a];
        rdy = !m_pend[a];
        for (int w = 0; w < 2; w++) begin
            if (we[w] && a != 0 && int'(waddr[w]) == a) begin
                d   = wdata[w];
                rdy = 1'b1;
            end
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int a = 0; a < 32; a++) n += m_pend[a] ? 1 : 0;
        return n;
    endfunction

    task automatic model_edge();
        bit written [32];
        for (int a = 0; a < 32; a++) written[a] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (we[w] && waddr[w] != 0) begin
                m_mem[waddr[w]]   = wdata[w];
                written[waddr[w]] = 1'b1;
            end
        end
        for (int a = 1; a < 32; a++) begin
            if (flush)                                m_pend[a] = 1'b0;
            else if (claim_valid && claim_addr == a)  m_pend[a] = 1'b1;
            else if (written[a])                      m_pend[a] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_vs_model(input string tag);
        logic [31:0] d;
        logic        r;
        for (int p = 0; p < 2; p++) begin
            model_read(int'(raddr[p]), d, r);
            chk($sformatf("%s rdata%0d", tag, p), rdata[p], d);
            chk($sformatf("%s rready%0d", tag, p), 32'(rready[p]), 32'(r));
        end
        chk($sformatf("%s pending_count", tag), 32'(pending_count), 32'(model_count()));
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = '0; waddr = '0; wdata = '0;
        claim_valid = 1'b0; claim_addr = '0; flush = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        cv;
        logic [4:0]  ca;
        logic        fl;
        logic [31:0] ed0;
        logic        er0;
        logic [31:0] ed1;
        logic        er1;
        logic [5:0]  ecnt;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] we_, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic cv, input logic [4:0] ca, input logic fl,
                                input logic [31:0] ed0, input logic er0,
                                input logic [31:0] ed1, input logic er1, input logic [5:0] ecnt);
        vec_t v;
        v.we = we_; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.cv = cv; v.ca = ca; v.fl = fl;
        v.ed0 = ed0; v.er0 = er0; v.ed1 = ed1; v.er1 = er1; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t tbl [21];

    initial begin
        logic [31:0] d;
        logic        r;

        // Directed sequence; each row is one cycle, expectations are outputs during that cycle.
        tbl[0]  = mk(2'b01, 7, 32'hDEADBEEF, 0, 0,      7, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 1, 0);
        tbl[1]  = mk(2'b00, 0, 0, 0, 0,                 7, 7, 0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
        tbl[2]  = mk(2'b01, 0, 32'hFFFF, 0, 0,          0, 7, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
        tbl[3]  = mk(2'b00, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[4]  = mk(2'b11, 3, 32'h11, 3, 32'h22,       3, 3, 0, 0, 0, 32'h22, 1, 32'h22, 1, 0);
        tbl[5]  = mk(2'b00, 0, 0, 0, 0,                 3, 0, 0, 0, 0, 32'h22, 1, 0, 1, 0);
        tbl[6]  = mk(2'b00, 0, 0, 0, 0,                 9, 9, 1, 9, 0, 0, 1, 0, 1, 0);
        tbl[7]  = mk(2'b00, 0, 0, 0, 0,                 9, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(2'b00, 0, 0, 0, 0,                 9, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(2'b00, 0, 0, 0, 0,                 9, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(2'b01, 9, 32'h55, 0, 0,            9, 9, 0, 0, 0, 32'h55, 1, 32'h55, 1, 1);
        tbl[11] = mk(2'b00, 0, 0, 0, 0,                 9, 9, 0, 0, 0, 32'h55, 1, 32'h55, 1, 0);
        tbl[12] = mk(2'b01, 4, 32'h44, 0, 0,            4, 0, 1, 4, 0, 32'h44, 1, 0, 1, 0);
        tbl[13] = mk(2'b00, 0, 0, 0, 0,                 4, 0, 1, 4, 0, 32'h44, 0, 0, 1, 1);
        tbl[14] = mk(2'b00, 0, 0, 0, 0,                 4, 0, 1, 0, 0, 32'h44, 0, 0, 1, 1);
        tbl[15] = mk(2'b00, 0, 0, 0, 0,                 4, 0, 1, 1, 0, 32'h44, 0, 0, 1, 1);
        tbl[16] = mk(2'b00, 0, 0, 0, 0,                 1, 4, 1, 2, 0, 0, 0, 32'h44, 0, 2);
        tbl[17] = mk(2'b00, 0, 0, 0, 0,                 2, 1, 1, 3, 0, 0, 0, 0, 0, 3);
        tbl[18] = mk(2'b01, 2, 32'h9, 0, 0,             2, 3, 1, 6, 1, 32'h9, 1, 32'h22, 0, 4);
        tbl[19] = mk(2'b00, 0, 0, 0, 0,                 6, 2, 0, 0, 0, 0, 1, 32'h9, 1, 0);
        tbl[20] = mk(2'b00, 0, 0, 0, 0,                 4, 3, 0, 0, 0, 32'h44, 1, 32'h22, 1, 0);

        // Reset held: every address reads 0 and ready on both ports.
        model_reset();
        idle_inputs();
        #2 reset = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(31 - a);
            #1;
            chk($sformatf("rst r%0d rdata0", a), rdata[0], 0);
            chk($sformatf("rst r%0d rdata1", 31 - a), rdata[1], 0);
            chk($sformatf("rst r%0d rready0", a), 32'(rready[0]), 1);
            chk($sformatf("rst r%0d rready1", 31 - a), 32'(rready[1]), 1);
        end
        chk("rst pending_count", 32'(pending_count), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(a ^ 5'h1f);
            #1;
            chk($sformatf("post-rst r%0d rdata0", a), rdata[0], 0);
            chk($sformatf("post-rst r%0d rready0", a), 32'(rready[0]), 1);
        end
        chk("post-rst pending_count", 32'(pending_count), 0);

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            we = tbl[i].we;
            waddr[0] = tbl[i].wa0; wdata[0] = tbl[i].wd0;
            waddr[1] = tbl[i].wa1; wdata[1] = tbl[i].wd1;
            raddr[0] = tbl[i].ra0; raddr[1] = tbl[i].ra1;
            claim_valid = tbl[i].cv; claim_addr = tbl[i].ca; flush = tbl[i].fl;
            #1;
            chk($sformatf("row%0d rdata0", i), rdata[0], tbl[i].ed0);
            chk($sformatf("row%0d rready0", i), 32'(rready[0]), 32'(tbl[i].er0));
            chk($sformatf("row%0d rdata1", i), rdata[1], tbl[i].ed1);
            chk($sformatf("row%0d rready1", i), 32'(rready[1]), 32'(tbl[i].er1));
            chk($sformatf("row%0d pending_count", i), 32'(pending_count), 32'(tbl[i].ecnt));
            run_cycle();
        end

        // Randomized traffic against the reference model, biased to low addresses for collisions.
        for (int c = 0; c < 600; c++) begin
            we          = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                waddr[p] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                wdata[p] = $urandom;
                raddr[p] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            claim_valid = ($urandom_range(0, 9) < 4);
            claim_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            check_vs_model($sformatf("rnd%0d", c));
            run_cycle();
        end

        // Asynchronous reset mid-run: state clears without a clock edge.
        idle_inputs();
        we = 2'b01; waddr[0] = 5; wdata[0] = 32'h1234;
        claim_valid = 1'b1; claim_addr = 8;
        #1;
        run_cycle();
        idle_inputs();
        raddr[0] = 5; raddr[1] = 8;
        #1;
        chk("pre-arst r5 rdata0", rdata[0], 32'h1234);
        chk("pre-arst r8 rready1", 32'(rready[1]), 0);
        check_vs_model("pre-arst");
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst r5 rdata0", rdata[0], 0);
        chk("arst r8 rready1", 32'(rready[1]), 1);
        chk("arst pending_count", 32'(pending_count), 0);
        #1 reset = 1'b1;
        run_cycle();
        #1;
        model_read(5, d, r);
        chk("after-arst r5 rdata0", rdata[0], d);
        chk("after-arst r8 rready1", 32'(rready[1]), 1);
        chk("after-arst pending_count", 32'(pending_count), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
